// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM states, ID width and destination-ID extraction for the bus arbiter
package bus_pkg;
    localparam int ID_W = 8;
    localparam int PKT_MAX = 1024;
    typedef enum logic [1:0] {IDLE, DELIVER, WAIT} bus_state_e;
    function automatic logic [ID_W-1:0] id_of(input logic [PKT_MAX-1:0] pkt, input int sz);
        return pkt[sz-1 -: ID_W];
    endfunction
endpackage

// File: rtl/bs_rbtr_lane.sv
// bs_rbtr_lane: one bus's round-robin grant FSM, packet register and destination decoder
module bs_rbtr_lane
    import bus_pkg::*;
#(
    parameter int drvrs = 4,
    parameter int pckg_sz = 16,
    parameter logic [ID_W-1:0] broadcast = {ID_W{1'b1}}
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push
);
    localparam int PW = $clog2(drvrs);
    bus_state_e state, state_d;
    logic [PW-1:0] last_grant, lg_d, src, src_d, sel, cand;
    logic [pckg_sz-1:0] pkt, pkt_d;
    logic [drvrs-1:0] pop_d, push_d;
    logic [ID_W-1:0] id;
    assign id = id_of(PKT_MAX'(pkt), pckg_sz);
    assign D_push = {drvrs{pkt}};
    // Scan from last_grant+drvrs down to last_grant+1 so the nearest pending device wins
    always_comb begin
        sel = last_grant;
        cand = last_grant;
        for (int k = drvrs; k >= 1; k--) begin
            cand = PW'((int'(last_grant) + k) % drvrs);
            if (pndng[cand]) sel = cand;
        end
    end
    always_comb begin
        state_d = state;
        pop_d = '0;
        push_d = '0;
        pkt_d = pkt;
        lg_d = last_grant;
        src_d = src;
        case (state)
            IDLE: if (|pndng) begin
                pop_d[sel] = 1'b1;
                pkt_d = D_pop[sel];
                lg_d = sel;
                src_d = sel;
                state_d = DELIVER;
            end
            DELIVER: begin
                for (int j = 0; j < drvrs; j++)
                    push_d[j] = (id == broadcast) ? (PW'(j) != src) : (id == ID_W'(j));
                state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pop <= '0;
            push <= '0;
            pkt <= '0;
            last_grant <= PW'(drvrs - 1);
            src <= '0;
        end else begin
            state <= state_d;
            pop <= pop_d;
            push <= push_d;
            pkt <= pkt_d;
            last_grant <= lg_d;
            src <= src_d;
        end
    end
endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// bs_gnrtr_n_rbtr: bus generator and arbiter, one independent arbitration lane per bus
module bs_gnrtr_n_rbtr
    import bus_pkg::*;
#(
    parameter int bits = 1,
    parameter int drvrs = 4,
    parameter int pckg_sz = 16,
    parameter logic [ID_W-1:0] broadcast = {8{1'b1}}
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]              pop,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);
    for (genvar i = 0; i < bits; i++) begin : g_lane
        bs_rbtr_lane #(
            .drvrs(drvrs),
            .pckg_sz(pckg_sz),
            .broadcast(broadcast)
        ) u_lane (
            .clk(clk),
            .reset(reset),
            .pndng(pndng[i]),
            .D_pop(D_pop[i]),
            .pop(pop[i]),
            .push(push[i]),
            .D_push(D_push[i])
        );
    end
endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// tb_bs_gnrtr_n_rbtr: table-driven and scoreboarded checks of the two-bus, six-device arbiter
module tb_bs_gnrtr_n_rbtr;
    localparam int NB = 2;
    localparam int ND = 6;
    localparam int PS = 16;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NB-1:0][ND-1:0] pndng, pop, push;
    logic [NB-1:0][ND-1:0][PS-1:0] D_pop, D_push;
    logic [PS-1:0] slot [NB][ND];
    bit full [NB][ND];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    typedef struct {
        int bus;
        int dev;
        logic [PS-1:0] data;
        logic [ND-1:0] mask;
    } vec_t;
    vec_t vt [7];
    vec_t sb [$];

    bs_gnrtr_n_rbtr #(
        .bits(NB),
        .drvrs(ND),
        .pckg_sz(PS),
        .broadcast(8'h0F)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pndng(pndng),
        .D_pop(D_pop),
        .pop(pop),
        .push(push),
        .D_push(D_push)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int b = 0; b < NB; b++)
            for (int d = 0; d < ND; d++) begin
                pndng[b][d] = full[b][d];
                D_pop[b][d] = slot[b][d];
            end
    endtask

    task automatic load(input int b, input int d, input logic [PS-1:0] data);
        slot[b][d] = data;
        full[b][d] = 1'b1;
        refresh();
    endtask

    // Advance one cycle, sample #1 after the edge and model the FWFT device FIFOs
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int b = 0; b < NB; b++) begin
            chk("pop_push_overlap", 32'(pop[b] & push[b]), 32'd0);
            for (int d = 0; d < ND; d++)
                if (pop[b][d]) full[b][d] = 1'b0;
        end
        refresh();
    endtask

    task automatic wait_pop(input int b, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (|pop[b]) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_pop timeout bus=%0d actual=none required=grant", b);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    initial begin
        bit ok;
        vec_t e;
        int prev;
        for (int b = 0; b < NB; b++)
            for (int d = 0; d < ND; d++) begin
                slot[b][d] = '0;
                full[b][d] = 1'b0;
            end
        refresh();
        vt[0] = '{0, 0, 16'h03AB, 6'b001000};
        vt[1] = '{0, 2, 16'h0F55, 6'b111011};
        vt[2] = '{0, 1, 16'h0912, 6'b000000};
        vt[3] = '{0, 4, 16'h0444, 6'b010000};
        vt[4] = '{0, 5, 16'h05AA, 6'b100000};
        vt[5] = '{1, 2, 16'h0677, 6'b000000};
        vt[6] = '{1, 3, 16'h0F00, 6'b110111};
        do_reset();
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_dpush", 32'(D_push[0][0]), 32'd0);
        chk("rst_dpush_b1", 32'(D_push[1][5]), 32'd0);

        for (int i = 0; i < 7; i++) begin
            load(vt[i].bus, vt[i].dev, vt[i].data);
            sb.push_back(vt[i]);
            wait_pop(vt[i].bus, ok);
            if (ok) begin
                e = sb.pop_front();
                chk($sformatf("v%0d_pop", i), 32'(pop[e.bus]), 32'(1 << e.dev));
                chk($sformatf("v%0d_pop_other", i), 32'(pop[1 - e.bus]), 32'd0);
                step();
                chk($sformatf("v%0d_pop_1cyc", i), 32'(pop[e.bus]), 32'd0);
                chk($sformatf("v%0d_push", i), 32'(push[e.bus]), 32'(e.mask));
                chk($sformatf("v%0d_push_other", i), 32'(push[1 - e.bus]), 32'd0);
                for (int d = 0; d < ND; d++)
                    chk($sformatf("v%0d_dpush%0d", i, d), 32'(D_push[e.bus][d]), 32'(e.data));
                step();
                chk($sformatf("v%0d_wait", i), 32'(pop[e.bus] | push[e.bus]), 32'd0);
            end else
                void'(sb.pop_front());
        end

        do_reset();
        for (int d = 0; d < ND; d++) load(0, d, 16'((d << 8) | (8'hA0 + d)));
        prev = 0;
        for (int n = 0; n < ND; n++) begin
            wait_pop(0, ok);
            if (!ok) break;
            chk($sformatf("rr_pop%0d", n), 32'(pop[0]), 32'(1 << n));
            if (n > 0) chk($sformatf("rr_gap%0d", n), 32'(cyc - prev), 32'd3);
            prev = cyc;
        end

        do_reset();
        load(0, 2, 16'h0233);
        wait_pop(0, ok);
        chk("mid_pop", 32'(pop[0]), 32'(1 << 2));
        chk("mid_dpush_pre", 32'(D_push[0][3]), 32'h0233);
        #1 reset = 1'b0;
        #1;
        chk("mid_pop_clr", 32'(pop[0]), 32'd0);
        chk("mid_push_clr", 32'(push[0]), 32'd0);
        chk("mid_dpush_clr", 32'(D_push[0][3]), 32'd0);
        step();
        reset = 1'b1;
        load(0, 4, 16'h0444);
        load(0, 0, 16'h0000);
        wait_pop(0, ok);
        chk("mid_first_grant", 32'(pop[0]), 32'd1);
        wait_pop(0, ok);
        chk("mid_second_grant", 32'(pop[0]), 32'(1 << 4));
        repeat (3) step();

        do_reset();
        load(0, 0, 16'h0111);
        load(1, 3, 16'h0022);
        wait_pop(0, ok);
        chk("two_pop_b0", 32'(pop[0]), 32'd1);
        chk("two_pop_b1", 32'(pop[1]), 32'(1 << 3));
        step();
        chk("two_push_b0", 32'(push[0]), 32'(1 << 1));
        chk("two_push_b1", 32'(push[1]), 32'd1);
        chk("two_data_b0", 32'(D_push[0][1]), 32'h0111);
        chk("two_data_b1", 32'(D_push[1][0]), 32'h0022);
        step();
        chk("two_wait", 32'(push | pop), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
